// File: rtl/seg7_pkg.sv
// Shared 7-segment constants (active low, bit0=a .. bit6=g) and reader FSM encoding.
package seg7_pkg;

  localparam logic [6:0] SegGlyph0 = 7'h40;
  localparam logic [6:0] SegGlyph1 = 7'h79;
  localparam logic [6:0] SegGlyph2 = 7'h24;
  localparam logic [6:0] SegGlyph3 = 7'h30;
  localparam logic [6:0] SegGlyph4 = 7'h19;
  localparam logic [6:0] SegGlyph5 = 7'h12;
  localparam logic [6:0] SegGlyph6 = 7'h02;
  localparam logic [6:0] SegGlyph7 = 7'h78;
  localparam logic [6:0] SegGlyph8 = 7'h00;
  localparam logic [6:0] SegGlyph9 = 7'h10;
  localparam logic [6:0] SegGlyphA = 7'h08;
  localparam logic [6:0] SegGlyphB = 7'h03;
  localparam logic [6:0] SegGlyphC = 7'h46;
  localparam logic [6:0] SegGlyphD = 7'h21;
  localparam logic [6:0] SegGlyphE = 7'h06;
  localparam logic [6:0] SegGlyphF = 7'h0E;
  localparam logic [6:0] SegBlank  = 7'h7F;

  typedef enum logic {StFill, StHold} asm_state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational reverse lookup of an active-low segment pattern to its hex nibble.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       hit_o,
  output logic [3:0] nib_o
);

  always_comb begin
    hit_o = 1'b1;
    nib_o = 4'h0;
    case (seg_i)
      SegGlyph0: nib_o = 4'h0;
      SegGlyph1: nib_o = 4'h1;
      SegGlyph2: nib_o = 4'h2;
      SegGlyph3: nib_o = 4'h3;
      SegGlyph4: nib_o = 4'h4;
      SegGlyph5: nib_o = 4'h5;
      SegGlyph6: nib_o = 4'h6;
      SegGlyph7: nib_o = 4'h7;
      SegGlyph8: nib_o = 4'h8;
      SegGlyph9: nib_o = 4'h9;
      SegGlyphA: nib_o = 4'hA;
      SegGlyphB: nib_o = 4'hB;
      SegGlyphC: nib_o = 4'hC;
      SegGlyphD: nib_o = 4'hD;
      SegGlyphE: nib_o = 4'hE;
      SegGlyphF: nib_o = 4'hF;
      default:   hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Reads back a 7-segment digit: stability filter, glyph decode, word assembler with
// valid/ready output and a one-deep skid for digits arriving while a word is held.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned NUM_DIGITS    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg,
  input  logic                    seg_en,
  output logic [3:0]              nib,
  output logic                    nib_valid,
  output logic                    bad_glyph,
  output logic [4*NUM_DIGITS-1:0] word,
  output logic                    word_valid,
  input  logic                    word_ready
);

  localparam int unsigned CntW  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned DigW  = $clog2(NUM_DIGITS + 1);
  localparam int unsigned WordW = 4 * NUM_DIGITS;

  logic [6:0]       seg_q, seg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       nib_q, nib_d;
  logic             nib_valid_q, nib_valid_d;
  logic             bad_glyph_q, bad_glyph_d;
  asm_state_e       state_q, state_d;
  logic [DigW-1:0]  dig_cnt_q, dig_cnt_d;
  logic [WordW-1:0] shift_q, shift_d;
  logic [WordW-1:0] word_q, word_d;
  logic [3:0]       skid_q, skid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             overflow_q, overflow_d;

  logic       accept, good, bad;
  logic       dec_hit;
  logic [3:0] dec_nib;

  seg7_glyph_decode u_decode (
    .seg_i (seg_q),
    .hit_o (dec_hit),
    .nib_o (dec_nib)
  );

  // Count saturates one past the accept value so a held pattern fires only once.
  always_comb begin
    seg_d  = seg_q;
    cnt_d  = cnt_q;
    accept = 1'b0;
    if (seg_en) begin
      seg_d  = seg;
      accept = (cnt_q == CntW'(STABLE_CYCLES - 1));
      if (seg != seg_q) begin
        cnt_d = '0;
      end else if (cnt_q != CntW'(STABLE_CYCLES)) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign good = accept & dec_hit;
  assign bad  = accept & ~dec_hit & (seg_q != SegBlank);

  always_comb begin
    nib_d       = good ? dec_nib : nib_q;
    nib_valid_d = good;
    bad_glyph_d = bad;
  end

  // Handshake is resolved first so a queued skid digit and a same-cycle accept both land in FILL.
  always_comb begin
    state_d      = state_q;
    dig_cnt_d    = dig_cnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    overflow_d   = overflow_q;

    if (state_q == StHold && word_ready) begin
      state_d      = StFill;
      skid_valid_d = 1'b0;
      if (skid_valid_q) begin
        shift_d   = WordW'(skid_q);
        dig_cnt_d = DigW'(1);
      end else begin
        shift_d   = '0;
        dig_cnt_d = '0;
      end
    end

    if (good) begin
      if (state_d == StFill) begin
        shift_d   = (shift_d << 4) | WordW'(dec_nib);
        dig_cnt_d = dig_cnt_d + DigW'(1);
      end else if (!skid_valid_d) begin
        skid_d       = dec_nib;
        skid_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (bad) begin
      dig_cnt_d    = '0;
      shift_d      = '0;
      skid_valid_d = 1'b0;
    end

    if (state_d == StFill && dig_cnt_d == DigW'(NUM_DIGITS)) begin
      word_d    = shift_d;
      state_d   = StHold;
      dig_cnt_d = '0;
      shift_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q        <= SegBlank;
      cnt_q        <= '0;
      nib_q        <= 4'h0;
      nib_valid_q  <= 1'b0;
      bad_glyph_q  <= 1'b0;
      state_q      <= StFill;
      dig_cnt_q    <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      skid_q       <= 4'h0;
      skid_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      cnt_q        <= cnt_d;
      nib_q        <= nib_d;
      nib_valid_q  <= nib_valid_d;
      bad_glyph_q  <= bad_glyph_d;
      state_q      <= state_d;
      dig_cnt_q    <= dig_cnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign nib        = nib_q;
  assign nib_valid  = nib_valid_q;
  assign bad_glyph  = bad_glyph_q;
  assign word       = word_q;
  assign word_valid = (state_q == StHold);

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed vector table, hand-written corner sequences, and a
// randomized run compared cycle by cycle against a run-length/queue reference model.
module tb_seg7_reader;

  localparam int S = 4;
  localparam int N = 4;

  logic        clk, reset, seg_en, word_ready;
  logic [6:0]  seg;
  logic [3:0]  nib;
  logic        nib_valid, bad_glyph, word_valid;
  logic [15:0] word;

  logic [6:0]  seg1;
  logic        ready1;
  logic [3:0]  nib1;
  logic        nv1, bad1, wv1;
  logic [7:0]  word1;

  seg7_reader #(.STABLE_CYCLES(S), .NUM_DIGITS(N)) dut (
    .clk(clk), .reset(reset), .seg(seg), .seg_en(seg_en), .nib(nib), .nib_valid(nib_valid),
    .bad_glyph(bad_glyph), .word(word), .word_valid(word_valid), .word_ready(word_ready)
  );

  seg7_reader #(.STABLE_CYCLES(1), .NUM_DIGITS(2)) dut1 (
    .clk(clk), .reset(reset), .seg(seg1), .seg_en(seg_en), .nib(nib1), .nib_valid(nv1),
    .bad_glyph(bad1), .word(word1), .word_valid(wv1), .word_ready(ready1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] glyph [16];
  initial glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_pass = 0;
  int n_total = 0;
  bit chk_model = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: run length of equal samples, digit queues, plain integers.
  logic [6:0]  m_seg = 7'h7F;
  int          m_run = 1;
  logic [3:0]  m_nib = 0;
  logic        m_nv = 0, m_bad = 0, m_hold = 0, m_ovf = 0;
  logic [15:0] m_word = 0;
  logic [3:0]  m_part [$];
  logic [3:0]  m_skid [$];

  task automatic m_step();
    int  idx;
    bit  fire;
    if (reset) begin
      m_seg = 7'h7F; m_run = 1; m_nib = 0; m_nv = 0; m_bad = 0; m_word = 0;
      m_hold = 0; m_ovf = 0; m_part.delete(); m_skid.delete();
      return;
    end
    fire = seg_en && (m_run == S);
    idx = -1;
    for (int i = 0; i < 16; i++) if (glyph[i] == m_seg) idx = i;
    m_nv = 0; m_bad = 0;
    if (fire && idx >= 0) begin m_nv = 1; m_nib = 4'(idx); end
    if (fire && idx < 0 && m_seg != 7'h7F) m_bad = 1;
    if (m_hold && word_ready) begin
      m_hold = 0; m_part = m_skid; m_skid.delete();
    end
    if (m_nv) begin
      if (!m_hold) m_part.push_back(m_nib);
      else if (m_skid.size() == 0) m_skid.push_back(m_nib);
      else m_ovf = 1;
    end
    if (m_bad) begin m_part.delete(); m_skid.delete(); end
    if (!m_hold && m_part.size() == N) begin
      m_word = 0;
      foreach (m_part[i]) m_word = (m_word << 4) | 16'(m_part[i]);
      m_hold = 1; m_part.delete();
    end
    if (seg_en) begin
      if (seg != m_seg) m_run = 1;
      else if (m_run < 1000) m_run++;
      m_seg = seg;
    end
  endtask

  task automatic step();
    m_step();
    @(posedge clk);
    #1;
    if (chk_model) begin
      chk("m_nib", 32'(nib), 32'(m_nib));
      chk("m_nib_valid", 32'(nib_valid), 32'(m_nv));
      chk("m_bad_glyph", 32'(bad_glyph), 32'(m_bad));
      chk("m_word", 32'(word), 32'(m_word));
      chk("m_word_valid", 32'(word_valid), 32'(m_hold));
      chk("m_overflow", 32'(dut.overflow_q), 32'(m_ovf));
    end
  endtask

  task automatic hold_seg(input logic [6:0] s, input int n, output int nv, output int nb);
    nv = 0; nb = 0; seg = s;
    repeat (n) begin
      step();
      nv += int'(nib_valid);
      nb += int'(bad_glyph);
    end
  endtask

  task automatic send(input logic [6:0] s);
    int a, b;
    hold_seg(s, 5, a, b);
  endtask

  typedef struct {
    logic [6:0]  seg;
    logic        ready;
    int          nv;
    int          nb;
    logic [3:0]  nib;
    logic        wv;
    logic [15:0] word;
  } vec_t;

  vec_t vecs [20];

  initial begin
    int nv, nb, first;
    reset = 1'b1; seg = 7'h7F; seg_en = 1'b1; word_ready = 1'b0; seg1 = 7'h7F; ready1 = 1'b0;

    vecs[0]  = '{7'h40, 1'b0, 1, 0, 4'h0, 1'b0, 16'h0000};
    vecs[1]  = '{7'h79, 1'b0, 1, 0, 4'h1, 1'b0, 16'h0000};
    vecs[2]  = '{7'h24, 1'b0, 1, 0, 4'h2, 1'b0, 16'h0000};
    vecs[3]  = '{7'h30, 1'b0, 1, 0, 4'h3, 1'b1, 16'h0123};
    vecs[4]  = '{7'h7F, 1'b0, 0, 0, 4'h3, 1'b1, 16'h0123};
    vecs[5]  = '{7'h55, 1'b0, 0, 1, 4'h3, 1'b1, 16'h0123};
    vecs[6]  = '{7'h19, 1'b1, 1, 0, 4'h4, 1'b0, 16'h0123};
    vecs[7]  = '{7'h12, 1'b1, 1, 0, 4'h5, 1'b0, 16'h0123};
    vecs[8]  = '{7'h02, 1'b1, 1, 0, 4'h6, 1'b0, 16'h0123};
    vecs[9]  = '{7'h78, 1'b1, 1, 0, 4'h7, 1'b1, 16'h4567};
    vecs[10] = '{7'h00, 1'b1, 1, 0, 4'h8, 1'b0, 16'h4567};
    vecs[11] = '{7'h10, 1'b1, 1, 0, 4'h9, 1'b0, 16'h4567};
    vecs[12] = '{7'h08, 1'b1, 1, 0, 4'hA, 1'b0, 16'h4567};
    vecs[13] = '{7'h03, 1'b1, 1, 0, 4'hB, 1'b1, 16'h89AB};
    vecs[14] = '{7'h46, 1'b1, 1, 0, 4'hC, 1'b0, 16'h89AB};
    vecs[15] = '{7'h21, 1'b1, 1, 0, 4'hD, 1'b0, 16'h89AB};
    vecs[16] = '{7'h06, 1'b1, 1, 0, 4'hE, 1'b0, 16'h89AB};
    vecs[17] = '{7'h0E, 1'b1, 1, 0, 4'hF, 1'b1, 16'hCDEF};
    vecs[18] = '{7'h06, 1'b1, 1, 0, 4'hE, 1'b0, 16'hCDEF};
    vecs[19] = '{7'h55, 1'b1, 0, 1, 4'hE, 1'b0, 16'hCDEF};

    // Reset state
    step(); step();
    chk("rst_nib", 32'(nib), 0);
    chk("rst_nib_valid", 32'(nib_valid), 0);
    chk("rst_bad_glyph", 32'(bad_glyph), 0);
    chk("rst_word", 32'(word), 0);
    chk("rst_word_valid", 32'(word_valid), 0);

    // Single held digit: one pulse, S+1 cycles after the first sample
    reset = 1'b0; seg = 7'h24; nv = 0; first = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (nib_valid) begin nv++; if (first == 0) first = i; end
    end
    chk("hold_pulses", 32'(nv), 1);
    chk("hold_latency", 32'(first), S + 1);
    chk("hold_nib", 32'(nib), 2);

    reset = 1'b1; step(); reset = 1'b0;

    foreach (vecs[i]) begin
      word_ready = vecs[i].ready;
      hold_seg(vecs[i].seg, 5, nv, nb);
      chk($sformatf("vec%0d_nv", i), 32'(nv), 32'(vecs[i].nv));
      chk($sformatf("vec%0d_bad", i), 32'(nb), 32'(vecs[i].nb));
      chk($sformatf("vec%0d_nib", i), 32'(nib), 32'(vecs[i].nib));
      chk($sformatf("vec%0d_wv", i), 32'(word_valid), 32'(vecs[i].wv));
      chk($sformatf("vec%0d_word", i), 32'(word), 32'(vecs[i].word));
    end
    chk("bad_clears_digits", 32'(dut.dig_cnt_q), 0);

    // Glitchy input never settles long enough
    word_ready = 1'b0; nv = 0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      seg = ((i / 2) % 2 == 0) ? 7'h24 : 7'h30;
      step();
      nv += int'(nib_valid); nb += int'(bad_glyph);
    end
    chk("toggle_nv", 32'(nv), 0);
    chk("toggle_bad", 32'(nb), 0);

    // Skid and overflow while a word is held
    send(7'h40); send(7'h79); send(7'h24); send(7'h30);
    chk("skid_hold_wv", 32'(word_valid), 1);
    chk("skid_hold_word", 32'(word), 32'h0123);
    send(7'h06);
    chk("skid_no_ovf", 32'(dut.overflow_q), 0);
    chk("skid_word_stable", 32'(word), 32'h0123);
    send(7'h02);
    chk("skid_ovf", 32'(dut.overflow_q), 1);
    seg = 7'h7F; word_ready = 1'b1; step(); word_ready = 1'b0;
    chk("skid_hs_wv", 32'(word_valid), 0);
    send(7'h79); send(7'h24); send(7'h30);
    chk("skid_ms_nibble", 32'(word[15:12]), 32'hE);
    chk("skid_word", 32'(word), 32'hE123);
    chk("skid_wv", 32'(word_valid), 1);

    // Reset mid-word
    seg = 7'h7F; word_ready = 1'b1; step(); word_ready = 1'b0;
    send(7'h40); send(7'h79);
    seg = 7'h7F; reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_nib", 32'(nib), 0);
    chk("mid_rst_nv", 32'(nib_valid), 0);
    chk("mid_rst_bad", 32'(bad_glyph), 0);
    chk("mid_rst_word", 32'(word), 0);
    chk("mid_rst_wv", 32'(word_valid), 0);
    chk("mid_rst_ovf", 32'(dut.overflow_q), 0);
    chk("mid_rst_digits", 32'(dut.dig_cnt_q), 0);

    // STABLE_CYCLES=1: each changed pattern accepted on its first sample
    seg1 = 7'h40; step();
    seg1 = 7'h79; step();
    chk("s1_nv_a", 32'(nv1), 1);
    chk("s1_nib_a", 32'(nib1), 0);
    seg1 = 7'h7F; step();
    chk("s1_nv_b", 32'(nv1), 1);
    chk("s1_nib_b", 32'(nib1), 1);
    chk("s1_wv", 32'(wv1), 1);
    chk("s1_word", 32'(word1), 32'h01);

    send(7'h40); send(7'h10); send(7'h08); send(7'h0E);
    chk("post_rst_word", 32'(word), 32'h09AF);
    chk("post_rst_wv", 32'(word_valid), 1);

    // Randomized run against the model
    chk_model = 1'b1;
    for (int k = 0; k < 500; k++) begin
      int r, h;
      r = int'($urandom_range(0, 9));
      if (r < 7) seg = glyph[$urandom_range(0, 15)];
      else if (r == 7) seg = 7'h7F;
      else if (r == 8) seg = 7'($urandom);
      h = int'($urandom_range(1, 7));
      repeat (h) begin
        seg_en = ($urandom_range(0, 9) != 0);
        word_ready = ($urandom_range(0, 2) == 0);
        reset = ($urandom_range(0, 299) == 0);
        step();
      end
    end
    reset = 1'b0; seg_en = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
